pipelined_fir_filter: RTL and testbench

- Fixed-coefficient, fully pipelined, transposed-form FIR low-pass filter; accepts one signed 16-bit sample every clock and produces one full-precision signed 40-bit result every clock.
- Sits in the DSP datapath between the sample source and downstream scaling or measurement logic.
- Output is unscaled: the coefficient Q-format is carried into the result.

---
 rtl/fir_params_pkg.sv | 34 +++
 rtl/fir_tap.sv | 23 ++
 rtl/pipelined_fir_filter.sv | 28 ++
 tb/tb_pipelined_fir_filter.sv | 115 +++++++++++
 4 files changed

// File: rtl/fir_params_pkg.sv
// fir_params_pkg: widths, types and the symmetric low-pass coefficient set shared by the FIR filter
package fir_params_pkg;
  localparam int NUM_TAPS = 100;
  localparam int IN_W     = 16;
  localparam int COEF_W   = 16;
  localparam int OUT_W    = 40;
  localparam int PROD_W   = IN_W + COEF_W;
  typedef logic signed [IN_W-1:0]   sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [OUT_W-1:0]  acc_t;
  // Hamming-windowed sinc, cutoff ~0.1 fs, Q1.15, mirrored about the centre
  localparam logic signed [COEF_W-1:0] COEFFS [NUM_TAPS] = '{
    -16'sd5,    -16'sd14,   -16'sd19,   -16'sd16,   -16'sd7,
     16'sd8,     16'sd23,    16'sd32,    16'sd29,    16'sd13,
    -16'sd15,   -16'sd43,   -16'sd60,   -16'sd55,   -16'sd23,
     16'sd26,    16'sd77,    16'sd106,   16'sd96,    16'sd41,
    -16'sd45,   -16'sd130,  -16'sd177,  -16'sd158,  -16'sd66,
     16'sd73,    16'sd209,   16'sd284,   16'sd251,   16'sd105,
    -16'sd115,  -16'sd330,  -16'sd446,  -16'sd396,  -16'sd166,
     16'sd182,   16'sd528,   16'sd722,   16'sd650,   16'sd277,
    -16'sd312,  -16'sd929,  -16'sd1321, -16'sd1249, -16'sd570,
     16'sd703,   16'sd2385,  16'sd4148,  16'sd5614,  16'sd6446,
     16'sd6446,  16'sd5614,  16'sd4148,  16'sd2385,  16'sd703,
    -16'sd570,  -16'sd1249, -16'sd1321, -16'sd929,  -16'sd312,
     16'sd277,   16'sd650,   16'sd722,   16'sd528,   16'sd182,
    -16'sd166,  -16'sd396,  -16'sd446,  -16'sd330,  -16'sd115,
     16'sd105,   16'sd251,   16'sd284,   16'sd209,   16'sd73,
    -16'sd66,   -16'sd158,  -16'sd177,  -16'sd130,  -16'sd45,
     16'sd41,    16'sd96,    16'sd106,   16'sd77,    16'sd26,
    -16'sd23,   -16'sd55,   -16'sd60,   -16'sd43,   -16'sd15,
     16'sd13,    16'sd29,    16'sd32,    16'sd23,    16'sd8,
    -16'sd7,    -16'sd16,   -16'sd19,   -16'sd14,   -16'sd5
  };
endpackage

// File: rtl/fir_tap.sv
// fir_tap: one transposed-form cell, registered product followed by registered partial sum
module fir_tap
  import fir_params_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  sample_t i_x,
  input  coef_t   i_h,
  input  acc_t    i_acc,
  output acc_t    o_acc
);
  logic signed [PROD_W-1:0] r_prod;
  acc_t r_acc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      r_prod <= PROD_W'(i_x) * PROD_W'(i_h);
      r_acc  <= i_acc + acc_t'(r_prod);
    end
  assign o_acc = r_acc;
endmodule

// File: rtl/pipelined_fir_filter.sv
// pipelined_fir_filter: transposed-form FIR, one sample in and one full-precision result out per clock
module pipelined_fir_filter
  import fir_params_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [IN_W-1:0]  inp,
  output logic signed [OUT_W-1:0] outp
);
  sample_t r_x;
  acc_t    w_acc [NUM_TAPS+1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_x <= '0;
    else r_x <= inp;
  assign w_acc[NUM_TAPS] = '0;
  // chain runs from the last tap down to tap 0, whose register is the output
  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    fir_tap u_tap (
      .clk   (clk),
      .rst_n (rst_n),
      .i_x   (r_x),
      .i_h   (COEFFS[k]),
      .i_acc (w_acc[k+1]),
      .o_acc (w_acc[k])
    );
  end
  assign outp = w_acc[0];
endmodule

// File: tb/tb_pipelined_fir_filter.sv
// tb_pipelined_fir_filter: directed vectors checked against hand values and a direct-form convolution model
module tb_pipelined_fir_filter;
  import fir_params_pkg::*;
  logic    clk = 1'b0;
  logic    rst_n;
  sample_t inp;
  acc_t    outp;
  int      n_chk = 0;
  int      n_err = 0;
  sample_t hist [NUM_TAPS+2];

  pipelined_fir_filter dut (.clk(clk), .rst_n(rst_n), .inp(inp), .outp(outp));

  always #5 clk = ~clk;

  // reference history: hist[0] is the sample taken at the latest edge
  always @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NUM_TAPS + 2; i++) hist[i] <= '0;
    else begin
      hist[0] <= inp;
      for (int i = 1; i < NUM_TAPS + 2; i++) hist[i] <= hist[i-1];
    end

  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < NUM_TAPS; k++) s += longint'(COEFFS[k]) * longint'(hist[k+2]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // called at a falling edge: drive one sample, step a cycle, compare with the model
  task automatic cyc(input sample_t x);
    inp = x;
    @(negedge clk);
    chk("model", 64'(outp), model_y());
  endtask

  initial begin
    longint sum_abs, pmax, mo, mm;
    real r;
    int v;
    rst_n = 1'b0;
    inp   = '0;
    @(negedge clk);
    for (int j = 0; j < 6; j++) begin
      inp = j[0] ? 16'sh7FFF : 16'sh8001;
      @(negedge clk);
      chk("rst_hold", 64'(outp), 64'sd0);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cyc('0);
      chk("post_rst", 64'(outp), 64'sd0);
    end
    cyc(16'sd1);
    for (int j = 0; j < NUM_TAPS + 3; j++) begin
      cyc('0);
      chk("imp_pos", 64'(outp), (j >= 1 && j <= NUM_TAPS) ? 64'(COEFFS[j-1]) : 64'sd0);
    end
    cyc(-16'sd32768);
    for (int j = 0; j < NUM_TAPS + 3; j++) begin
      cyc('0);
      chk("imp_neg", 64'(outp), (j >= 1 && j <= NUM_TAPS) ? -64'sd32768 * 64'(COEFFS[j-1]) : 64'sd0);
    end
    for (int j = 0; j < NUM_TAPS + 4; j++) cyc(16'sd16384);
    chk("dc_step", 64'(outp), 64'sd536117248);
    cyc(16'sd16384);
    chk("dc_hold", 64'(outp), 64'sd536117248);
    sum_abs = 0;
    for (int k = 0; k < NUM_TAPS; k++)
      sum_abs += (COEFFS[k] < 0) ? -longint'(COEFFS[k]) : longint'(COEFFS[k]);
    for (int j = 0; j < NUM_TAPS; j++)
      cyc(COEFFS[NUM_TAPS-1-j] < 0 ? -16'sd32767 : 16'sd32767);
    cyc('0);
    cyc('0);
    chk("ovf_peak", 64'(outp), sum_abs * 32767);
    for (int j = 0; j < 60; j++) cyc(sample_t'($urandom));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 64'(outp), 64'sd0);
    inp = sample_t'($urandom);
    repeat (2) begin
      @(negedge clk);
      chk("rst_low", 64'(outp), 64'sd0);
    end
    #2 rst_n = 1'b1;
    for (int j = 0; j < NUM_TAPS + 20; j++) cyc(sample_t'($urandom));
    pmax = 0;
    for (int i = 1; i <= 13; i++) begin
      mo = -(64'sd1 <<< 62);
      mm = -(64'sd1 <<< 62);
      for (int n = 0; n < 2170; n++) begin
        r = 32767.0 * $sin(2.0 * 3.14159265358979 * real'(i * n) / 27.0);
        v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
        cyc(sample_t'(v));
        if (n >= 170) begin
          if (64'(outp) > mo) mo = 64'(outp);
          if (model_y() > mm) mm = model_y();
        end
      end
      chk("sine_max", mo, mm);
      if (i == 1) pmax = mo;
      if (i >= 5) chk("stopband_40db", (mo * 100 <= pmax) ? 64'sd1 : 64'sd0, 64'sd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
